reg_lock_tracker: RTL

- Holds the sequential register-lock scoreboard and memory-busy flag for the issue stage.
- Feeds `reg_gnt_ckr` its `locks_i`/`mem_busy_i` inputs.
- Consumes arbiter grants to set locks, and writeback/memory completions to clear them.
- Owns the blocking-instruction state machine: while a blocking instruction is in flight, all registers read as locked; on completion the pre-block lock set is restored.

---
 rtl/reg_lock_tracker_pkg.sv | 24 ++
 rtl/reg_lock_tracker_onehot_dec.sv | 21 ++
 rtl/reg_lock_tracker.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/reg_lock_tracker_pkg.sv
// Shared types and helpers for the issue-stage register lock tracker.
package maverickOne_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int REG_CNT_W = $clog2(NUM_REGS + 1);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BLOCK = 1'b1
  } lock_state_e;

  function automatic logic [REG_CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] vec);
    logic [REG_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + REG_CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_lock_tracker_onehot_dec.sv
// Register index to one-hot decoder; register 0 is hardwired and never tracked.
module reg_onehot_dec #(
  parameter int NR    = 32,
  parameter int IDX_W = $clog2(NR)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             valid,
  output logic [NR-1:0]    onehot
);

  // One-hot expansion, suppressed for the zero register
  always_comb begin
    onehot = '0;
    if (valid && (idx != '0)) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/reg_lock_tracker.sv
// Register-lock scoreboard, memory-busy flag and blocking-instruction FSM
// feeding reg_gnt_ckr. All outputs come straight from flops.
module reg_lock_tracker
  import maverickOne_pkg::*;
#(
  parameter int NR  = NUM_REGS,
  parameter int NWB = 2
) (
  input  logic                              clk_i,
  input  logic                              arst_i,
  input  logic                              gnt_i,
  input  logic [$clog2(NR)-1:0]             gnt_rd_i,
  input  logic                              gnt_blocking_i,
  input  logic                              gnt_mem_op_i,
  input  logic [NWB-1:0]                    wb_valid_i,
  input  logic [NWB-1:0][$clog2(NR)-1:0]    wb_rd_i,
  input  logic                              mem_done_i,
  input  logic                              blk_done_i,
  input  logic                              flush_i,
  output logic [NR-1:0]                     locks_o,
  output logic                              mem_busy_o,
  output logic                              blocked_o,
  output logic [$clog2(NR+1)-1:0]           n_locked_o,
  output logic                              proto_err_o
);

  localparam int IDX_W = $clog2(NR);
  localparam int CNT_W = $clog2(NR + 1);

  lock_state_e          state_r, state_d_s;
  logic [NR-1:0]        locks_r, locks_d_s;
  logic [NR-1:0]        shadow_r, shadow_d_s;
  logic                 mem_busy_r, mem_busy_d_s;
  logic                 proto_err_r, proto_err_d_s;
  logic [NR-1:0]        locks_out_r;
  logic [CNT_W-1:0]     n_locked_r;
  logic [NWB-1:0][NR-1:0] wb_oh_s;
  logic [NR-1:0]        set_mask_s;
  logic [NR-1:0]        clr_mask_s;
  logic                 in_idle_s;

  for (genvar p = 0; p < NWB; p++) begin : g_wb_dec
    reg_onehot_dec #(.NR(NR), .IDX_W(IDX_W)) u_wb_dec (
      .idx    (wb_rd_i[p]),
      .valid  (wb_valid_i[p]),
      .onehot (wb_oh_s[p])
    );
  end

  reg_onehot_dec #(.NR(NR), .IDX_W(IDX_W)) u_gnt_dec (
    .idx    (gnt_rd_i),
    .valid  (gnt_i & ~gnt_blocking_i),
    .onehot (set_mask_s)
  );

  // Merge writeback releases; duplicates simply OR together
  always_comb begin
    clr_mask_s = '0;
    for (int p = 0; p < NWB; p++) begin
      clr_mask_s = clr_mask_s | wb_oh_s[p];
    end
  end

  // Next-state: flush dominates, grants only act outside BLOCK
  always_comb begin
    state_d_s     = state_r;
    locks_d_s     = locks_r;
    shadow_d_s    = shadow_r;
    mem_busy_d_s  = mem_busy_r;
    proto_err_d_s = 1'b0;
    in_idle_s     = (state_r == IDLE);
    if (flush_i) begin
      state_d_s    = IDLE;
      locks_d_s    = '0;
      shadow_d_s   = '0;
      mem_busy_d_s = 1'b0;
    end else begin
      proto_err_d_s = (mem_done_i & ~mem_busy_r) | (in_idle_s & blk_done_i) |
                      (~in_idle_s & gnt_i);
      // Set wins over done so a back-to-back memory op stays busy
      if (in_idle_s && gnt_i && gnt_mem_op_i) begin
        mem_busy_d_s = 1'b1;
      end else if (mem_done_i) begin
        mem_busy_d_s = 1'b0;
      end else begin
        mem_busy_d_s = mem_busy_r;
      end
      case (state_r)
        IDLE: begin
          locks_d_s = (locks_r & ~clr_mask_s) | set_mask_s;
          if (gnt_i && gnt_blocking_i) begin
            state_d_s  = BLOCK;
            shadow_d_s = locks_r & ~clr_mask_s;
          end else begin
            state_d_s  = IDLE;
            shadow_d_s = shadow_r;
          end
        end
        BLOCK: begin
          shadow_d_s = shadow_r & ~clr_mask_s;
          if (blk_done_i) begin
            state_d_s = IDLE;
            locks_d_s = shadow_r & ~clr_mask_s;
          end else begin
            state_d_s = BLOCK;
            locks_d_s = locks_r;
          end
        end
        default: begin
          state_d_s  = IDLE;
          locks_d_s  = '0;
          shadow_d_s = '0;
        end
      endcase
    end
  end

  // State and registered output images
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_r     <= IDLE;
      locks_r     <= '0;
      shadow_r    <= '0;
      mem_busy_r  <= 1'b0;
      proto_err_r <= 1'b0;
      locks_out_r <= '0;
      n_locked_r  <= '0;
    end else begin
      state_r     <= state_d_s;
      locks_r     <= locks_d_s;
      shadow_r    <= shadow_d_s;
      mem_busy_r  <= mem_busy_d_s;
      proto_err_r <= proto_err_d_s;
      locks_out_r <= (state_d_s == BLOCK) ? '1 : locks_d_s;
      n_locked_r  <= popcount(locks_d_s);
    end
  end

  assign locks_o     = locks_out_r;
  assign mem_busy_o  = mem_busy_r;
  assign blocked_o   = (state_r == BLOCK);
  assign n_locked_o  = n_locked_r;
  assign proto_err_o = proto_err_r;

endmodule
